// File: rtl/lc3b_fetch_unit_if.sv
// Fetch unit bus: instruction memory read/resp port, redirect input and
// the valid/ready instruction handshake toward the IR stage.
interface lc3b_fetch_unit_if;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_plus2;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_rdata,
    input  mem_resp,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    output inst_pc_plus2
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_rdata,
    output mem_resp,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    input  inst_pc_plus2
  );
endinterface

// File: rtl/lc3b_fetch_unit.sv
// LC-3b fetch stage: owns fetch PC, prefetch queue and redirect squash.
// Optional FETCH_PERF_EN adds stall/flush counters.
module lc3b_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic clk,
  input  logic reset_n,
  lc3b_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_stall_count,
  output logic [15:0] flush_count
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_addr;
  logic [15:0]   target;
  logic [15:0]   pc_q   [DEPTH];
  logic [15:0]   word_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1))
      ptr_inc = '0;
    else
      ptr_inc = p + PW'(1);
  endfunction

  assign target = bus.redirect_pc & 16'hFFFE;
  // Redirect wins over both queue ports in the same cycle.
  assign push  = (state == FETCH) && bus.mem_resp && !bus.redirect;
  assign pop   = bus.inst_valid && bus.inst_ready && !bus.redirect;
  assign issue = (state == IDLE) && (count < CW'(DEPTH)) && !bus.redirect;

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (issue)
          state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.mem_resp)
          state_nxt = IDLE;
        else if (bus.redirect)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.mem_resp)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read      = (state != IDLE);
    bus.mem_address   = req_addr;
    bus.inst_valid    = (count != '0);
    bus.inst          = word_q[rd_ptr];
    bus.inst_pc       = pc_q[rd_ptr];
    bus.inst_pc_plus2 = pc_q[rd_ptr] + 16'd2;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc <= {RESET_PC[15:1], 1'b0};
      req_addr <= {RESET_PC[15:1], 1'b0};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue)
        req_addr <= fetch_pc;
      if (bus.redirect) begin
        fetch_pc <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 16'd2;
          wr_ptr   <= ptr_inc(wr_ptr);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= req_addr;
      word_q[wr_ptr] <= bus.mem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_stall_count <= '0;
      flush_count       <= '0;
    end else begin
      if (bus.inst_ready && !bus.inst_valid &&
          fetch_stall_count != '1)
        fetch_stall_count <= fetch_stall_count + 32'd1;
      // A DRAIN read is already doomed, so only a live FETCH counts.
      if (bus.redirect && (count != '0 || state == FETCH) &&
          flush_count != '1)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Bench for lc3b_fetch_unit: vector table, directed corners and a
// randomized run against a transaction-level queue model.
module tb_lc3b_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [15:0] RPC   = 16'h0000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lc3b_fetch_unit_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_stall_count;
  logic [15:0] flush_count;
`endif

  lc3b_fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_stall_count(fetch_stall_count),
    .flush_count(flush_count)
`endif
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } ent_t;

  typedef struct packed {
    logic        rsp;
    logic [15:0] dat;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_ad;
    logic        e_v;
    logic [15:0] e_in;
    logic [15:0] e_pc;
    logic [15:0] e_p2;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  ent_t        mq[$];
  logic [15:0] m_fpc;
  logic [15:0] m_req;
  logic        m_doomed;
  logic        m_exp_rd;
  logic        prev_rd;
  logic        sb_on = 1'b0;

  logic auto_mem = 1'b0;
  logic rand_lat = 1'b0;
  int   lat = 1;
  int   wait_cnt = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    logic rd, rs, v, rdy, rdir, rn, acc;
    logic [15:0] ad, rdat, rpc;
    ent_t h;
    if (auto_mem) begin
      bus.mem_resp  = bus.mem_read && (wait_cnt >= lat);
      bus.mem_rdata = mem_word(bus.mem_address);
    end
    rd   = bus.mem_read;
    rs   = bus.mem_resp;
    ad   = bus.mem_address;
    rdat = bus.mem_rdata;
    v    = bus.inst_valid;
    rdy  = bus.inst_ready;
    rdir = bus.redirect;
    rpc  = bus.redirect_pc;
    rn   = reset_n;
    if (sb_on) begin
      chk1("sb_mem_read", rd, m_exp_rd);
      if (rd && !prev_rd) begin
        chk16("sb_req_addr", ad, m_fpc);
        m_req = ad;
      end else if (rd) begin
        chk16("sb_addr_hold", ad, m_req);
      end
      chk1("sb_inst_valid", v, mq.size() != 0);
      if (mq.size() != 0 && v) begin
        h = mq[0];
        chk16("sb_inst", bus.inst, h.word);
        chk16("sb_inst_pc", bus.inst_pc, h.pc);
        chk16("sb_inst_pc_plus2", bus.inst_pc_plus2, h.pc + 16'd2);
      end
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      if (rd && !rs) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (rd && rs && rand_lat)
          lat = $urandom_range(0, 3);
      end
    end
    if (!rn) begin
      mq.delete();
      m_fpc    = RPC;
      m_doomed = 1'b0;
      m_exp_rd = 1'b0;
      sb_on    = 1'b1;
      wait_cnt = 0;
    end else begin
      if (rd && rs)
        m_exp_rd = 1'b0;
      else if (!rd)
        m_exp_rd = (mq.size() < DEPTH) && !rdir;
      else
        m_exp_rd = 1'b1;
      acc = rd && rs && !m_doomed && !rdir;
      if (rdir) begin
        mq.delete();
        m_fpc = rpc & 16'hFFFE;
        if (rd && !rs)
          m_doomed = 1'b1;
      end else begin
        if (mq.size() != 0 && rdy)
          void'(mq.pop_front());
        if (acc) begin
          mq.push_back('{pc: m_req, word: rdat});
          m_fpc = m_fpc + 16'd2;
        end
      end
      if (rd && rs)
        m_doomed = 1'b0;
    end
    prev_rd = rn ? rd : 1'b0;
  endtask

  // kind 0: mem_read, 1: mem_read at address a, 2: inst_valid
  task automatic wait_for(input string nm, input int kind,
                          input logic [15:0] a, input int limit);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      case (kind)
        0: hit = bus.mem_read;
        1: hit = bus.mem_read && (bus.mem_address == a);
        default: hit = bus.inst_valid;
      endcase
      if (hit)
        break;
      if (i < limit)
        tick();
    end
    chk1({nm, "_seen"}, hit, 1'b1);
  endtask

  task automatic do_reset();
    auto_mem        = 1'b0;
    rand_lat        = 1'b0;
    reset_n         = 1'b0;
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = 16'h0000;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.inst_ready  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0,
               16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0,
               16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0,
               16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1,
               16'h1234, 16'h0000, 16'h0002};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0,
               16'h0000, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 16'h5678, 1'b1, 1'b1, 16'h0002, 1'b0,
               16'h0000, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1,
               16'h5678, 16'h0002, 16'h0004};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0,
               16'h0000, 16'h0000, 16'h0000};

    do_reset();
    chk1("reset_mem_read", bus.mem_read, 1'b0);
    chk1("reset_inst_valid", bus.inst_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      chk1($sformatf("tbl%0d_mem_read", i), bus.mem_read, tbl[i].e_rd);
      if (tbl[i].e_rd)
        chk16($sformatf("tbl%0d_addr", i), bus.mem_address, tbl[i].e_ad);
      chk1($sformatf("tbl%0d_valid", i), bus.inst_valid, tbl[i].e_v);
      if (tbl[i].e_v) begin
        chk16($sformatf("tbl%0d_inst", i), bus.inst, tbl[i].e_in);
        chk16($sformatf("tbl%0d_pc", i), bus.inst_pc, tbl[i].e_pc);
        chk16($sformatf("tbl%0d_pc2", i), bus.inst_pc_plus2, tbl[i].e_p2);
      end
      bus.mem_resp   = tbl[i].rsp;
      bus.mem_rdata  = tbl[i].dat;
      bus.inst_ready = tbl[i].rdy;
      tick();
    end

    // Back-pressure: queue fills to DEPTH, then resumes at 0x0004.
    do_reset();
    lat = 0;
    wait_cnt = 0;
    auto_mem = 1'b1;
    repeat (12) tick();
    chk1("bp_valid", bus.inst_valid, 1'b1);
    chk1("bp_no_read", bus.mem_read, 1'b0);
    chk16("bp_head_pc", bus.inst_pc, 16'h0000);
    chk16("bp_head_inst", bus.inst, mem_word(16'h0000));
    bus.inst_ready = 1'b1;
    wait_for("bp_resume", 0, 16'h0000, 10);
    chk16("bp_resume_addr", bus.mem_address, 16'h0004);

    // Redirect while the 0x0006 read is pending.
    do_reset();
    lat = 1;
    wait_cnt = 0;
    auto_mem = 1'b1;
    bus.inst_ready = 1'b1;
    wait_for("rd_req6", 1, 16'h0006, 40);
    lat = 3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h3001;
    tick();
    bus.redirect = 1'b0;
    begin
      int held;
      held = 0;
      for (int i = 0; i < 10; i++) begin
        chk1("rd_valid_low", bus.inst_valid, 1'b0);
        if (!(bus.mem_read && bus.mem_address == 16'h0006))
          break;
        held++;
        tick();
      end
      chk16("rd_hold_cycles", 16'(held), 16'd3);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_read)
        break;
      chk1("rd_gap_valid_low", bus.inst_valid, 1'b0);
      tick();
    end
    chk16("rd_new_addr", bus.mem_address, 16'h3000);
    for (int i = 0; i < 10; i++) begin
      if (bus.inst_valid)
        break;
      tick();
    end
    chk1("rd_new_valid", bus.inst_valid, 1'b1);
    chk16("rd_new_pc", bus.inst_pc, 16'h3000);
    chk16("rd_new_inst", bus.inst, mem_word(16'h3000));

    // Redirect coincident with the response for 0x0008.
    do_reset();
    lat = 1;
    wait_cnt = 0;
    auto_mem = 1'b1;
    bus.inst_ready = 1'b1;
    wait_for("rr_req8", 1, 16'h0008, 40);
    auto_mem = 1'b0;
    bus.mem_resp = 1'b0;
    tick();
    bus.mem_resp    = 1'b1;
    bus.mem_rdata   = 16'hBEEF;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h4000;
    tick();
    bus.mem_resp = 1'b0;
    bus.redirect = 1'b0;
    chk1("rr_valid_low", bus.inst_valid, 1'b0);
    chk1("rr_idle", bus.mem_read, 1'b0);
    tick();
    chk1("rr_read", bus.mem_read, 1'b1);
    chk16("rr_addr", bus.mem_address, 16'h4000);
    wait_cnt = 0;
    auto_mem = 1'b1;
    wait_for("rr_inst", 2, 16'h0000, 10);
    chk16("rr_inst_pc", bus.inst_pc, 16'h4000);

    // PC wrap at 0xFFFE.
    do_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFC;
    tick();
    bus.redirect = 1'b0;
    lat = 0;
    wait_cnt = 0;
    auto_mem = 1'b1;
    repeat (10) tick();
    chk16("wr_head_pc", bus.inst_pc, 16'hFFFC);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.inst_valid && bus.inst_pc == 16'hFFFE)
        break;
      tick();
    end
    chk16("wr_pc_fffe", bus.inst_pc, 16'hFFFE);
    chk16("wr_plus2_wrap", bus.inst_pc_plus2, 16'h0000);
    wait_for("wr_next", 0, 16'h0000, 10);
    chk16("wr_next_addr", bus.mem_address, 16'h0000);

    // Reset mid-fetch, then a stray response.
    do_reset();
    lat = 5;
    wait_cnt = 0;
    auto_mem = 1'b1;
    bus.inst_ready = 1'b1;
    wait_for("rs_fetch", 0, 16'h0000, 10);
    auto_mem = 1'b0;
    bus.mem_resp = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk1("rs_read_low", bus.mem_read, 1'b0);
    chk1("rs_valid_low", bus.inst_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk16("rs_stall_cnt", fetch_stall_count[15:0], 16'h0000);
    chk16("rs_flush_cnt", flush_count, 16'h0000);
`endif
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    tick();
    bus.mem_resp = 1'b0;
    chk1("rs_stray_ignored", bus.inst_valid, 1'b0);
    chk1("rs_restart_read", bus.mem_read, 1'b1);
    chk16("rs_restart_addr", bus.mem_address, RPC);
    wait_cnt = 0;
    auto_mem = 1'b1;
    wait_for("rs_inst", 2, 16'h0000, 20);
    chk16("rs_inst", bus.inst, mem_word(RPC));

    // Randomized traffic against the queue model.
    do_reset();
    wait_cnt = 0;
    lat = 1;
    rand_lat = 1'b1;
    auto_mem = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      bus.redirect   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.redirect_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
      else
        bus.redirect_pc = 16'($urandom);
      tick();
    end
    bus.redirect = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
